// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller port bundle: ID/EX/MEM register info in, forwarding selects and
// pipeline-control enables out.
interface pipe_hazard_ctrl_if;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       use_rs;
  logic       use_rt;
  logic       dmc;
  logic [4:0] ern;
  logic       ewreg;
  logic       em2reg;
  logic [4:0] mrn;
  logic       mwreg;
  logic       mm2reg;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic       wpcir;
  logic       dereg_en;
  logic       bubble;
  logic       em_bubble;
  logic       mc_start;
  logic       mc_busy;

  // Pipeline side: drives the register info, consumes the controls.
  modport master (
    output rs, rt, use_rs, use_rt, dmc, ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    input  fwda, fwdb, wpcir, dereg_en, bubble, em_bubble, mc_start, mc_busy
  );

  // Controller side.
  modport slave (
    input  rs, rt, use_rs, use_rt, dmc, ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    output fwda, fwdb, wpcir, dereg_en, bubble, em_bubble, mc_start, mc_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/forwarding controller around ID/EX: RAW forwarding selects, load-use stalls,
// and a small FSM that holds the front end while a multi-cycle EX op occupies EX.
module pipe_hazard_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               MULTI    = (MC_CYCLES > 1);

  state_t           state_p0, state_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             mc_start_p1, mc_start_nxt;
  logic [1:0]       fwda_raw, fwdb_raw;
  logic             lu;

  // EX wins over MEM; a load still in EX has no data yet, and r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       use_src,
    input logic [4:0] ern,
    input logic       ewreg,
    input logic       em2reg,
    input logic [4:0] mrn,
    input logic       mwreg,
    input logic       mm2reg
  );
    if (ewreg && (ern != 5'd0) && use_src && (src == ern) && !em2reg)
      return 2'b01;
    else if (mwreg && (mrn != 5'd0) && (src == mrn))
      return mm2reg ? 2'b11 : 2'b10;
    else
      return 2'b00;
  endfunction

  function automatic logic load_use(
    input logic [4:0] rs,
    input logic       use_rs,
    input logic [4:0] rt,
    input logic       use_rt,
    input logic [4:0] ern,
    input logic       ewreg,
    input logic       em2reg
  );
    return ewreg && em2reg && (ern != 5'd0) &&
           ((use_rs && (rs == ern)) || (use_rt && (rt == ern)));
  endfunction

  always_comb begin
    fwda_raw = fwd_sel(hz.rs, hz.use_rs, hz.ern, hz.ewreg, hz.em2reg,
                       hz.mrn, hz.mwreg, hz.mm2reg);
    fwdb_raw = fwd_sel(hz.rt, hz.use_rt, hz.ern, hz.ewreg, hz.em2reg,
                       hz.mrn, hz.mwreg, hz.mm2reg);
    lu       = load_use(hz.rs, hz.use_rs, hz.rt, hz.use_rt,
                        hz.ern, hz.ewreg, hz.em2reg);
  end

  // ---- state register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      mc_start_p1 <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      cnt_p0      <= cnt_nxt;
      mc_start_p1 <= mc_start_nxt;
    end
  end

  // ---- next state ----
  always_comb begin
    state_nxt    = state_p0;
    cnt_nxt      = cnt_p0;
    mc_start_nxt = 1'b0;
    case (state_p0)
      IDLE: begin
        // A load-use bubble takes precedence; the launch retries next cycle.
        if (hz.dmc && !lu) begin
          mc_start_nxt = 1'b1;
          if (MULTI) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt_p0 != '0)
          cnt_nxt = cnt_p0 - CNT_ONE;
        if (cnt_p0 <= CNT_ONE)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- outputs ----
  always_comb begin
    hz.fwda      = 2'b00;
    hz.fwdb      = 2'b00;
    hz.wpcir     = 1'b1;
    hz.dereg_en  = 1'b1;
    hz.bubble    = 1'b0;
    hz.em_bubble = 1'b0;
    hz.mc_start  = 1'b0;
    hz.mc_busy   = 1'b0;
    if (reset) begin
      // Flush both control registers so a partial op never reaches MEM.
      hz.bubble    = 1'b1;
      hz.em_bubble = 1'b1;
    end else begin
      hz.fwda     = fwda_raw;
      hz.fwdb     = fwdb_raw;
      hz.mc_start = mc_start_p1;
      case (state_p0)
        IDLE: begin
          if (lu) begin
            hz.wpcir  = 1'b0;
            hz.bubble = 1'b1;
          end
        end
        BUSY: begin
          hz.wpcir     = 1'b0;
          hz.dereg_en  = 1'b0;
          hz.mc_busy   = 1'b1;
          hz.em_bubble = (cnt_p0 != CNT_ONE);
        end
        default: begin
          hz.bubble    = 1'b1;
          hz.em_bubble = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MC_CYCLES=4): vector table, hand-written
// multi-cycle sequences and a randomized forwarding/load-use sweep, all via a scoreboard.
module tb_pipe_hazard_ctrl;

  logic clock;
  logic reset;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MC_CYCLES(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clock = ~clock;

  // {fwda, fwdb, wpcir, dereg_en, bubble, em_bubble, mc_start, mc_busy}
  localparam logic [9:0] IDLEV = 10'b00_00_1_1_0_0_0_0;
  localparam logic [9:0] RSTV  = 10'b00_00_1_1_1_1_0_0;
  localparam logic [9:0] STALL = 10'b00_00_0_1_1_0_0_0;
  localparam logic [9:0] BSTRT = 10'b00_00_0_0_0_1_1_1;
  localparam logic [9:0] BMID  = 10'b00_00_0_0_0_1_0_1;
  localparam logic [9:0] BLAST = 10'b00_00_0_0_0_0_0_1;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       dmc;
    logic [4:0] ern;
    logic       ewreg;
    logic       em2reg;
    logic [4:0] mrn;
    logic       mwreg;
    logic       mm2reg;
    logic [9:0] exp;
  } vec_t;

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;

  wire logic [9:0] outs = {hz.fwda, hz.fwdb, hz.wpcir, hz.dereg_en, hz.bubble,
                           hz.em_bubble, hz.mc_start, hz.mc_busy};

  function automatic vec_t mk(input string name, input logic rst,
                              input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt, input logic dmc,
                              input logic [4:0] ern, input logic ewreg, input logic em2reg,
                              input logic [4:0] mrn, input logic mwreg, input logic mm2reg,
                              input logic [9:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
    v.dmc = dmc; v.ern = ern; v.ewreg = ewreg; v.em2reg = em2reg;
    v.mrn = mrn; v.mwreg = mwreg; v.mm2reg = mm2reg; v.exp = exp;
    return v;
  endfunction

  function automatic logic [9:0] fx(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic [9:0] base);
    return {fa, fb, base[5:0]};
  endfunction

  // Reference forwarding rule, written from the operand-select definition.
  function automatic logic [1:0] mfwd(input logic [4:0] s, input logic u,
                                      input logic [4:0] ern, input logic ewreg,
                                      input logic em2reg, input logic [4:0] mrn,
                                      input logic mwreg, input logic mm2reg);
    if (ewreg && ern != 0 && u && s == ern && !em2reg) return 2'b01;
    if (mwreg && mrn != 0 && s == mrn) return mm2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input vec_t v);
    reset     = v.rst;
    hz.rs     = v.rs;
    hz.use_rs = v.urs;
    hz.rt     = v.rt;
    hz.use_rt = v.urt;
    hz.dmc    = v.dmc;
    hz.ern    = v.ern;
    hz.ewreg  = v.ewreg;
    hz.em2reg = v.em2reg;
    hz.mrn    = v.mrn;
    hz.mwreg  = v.mwreg;
    hz.mm2reg = v.mm2reg;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b (fa fb w d b eb ms mb)", n, outs, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tbl[12];

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    hz.rs = '0; hz.rt = '0; hz.use_rs = 0; hz.use_rt = 0; hz.dmc = 0;
    hz.ern = '0; hz.ewreg = 0; hz.em2reg = 0; hz.mrn = '0; hz.mwreg = 0; hz.mm2reg = 0;
    @(posedge clock);
    #1;

    //          name          rst rs urs rt urt dmc ern ew em mrn mw mm exp
    tbl[0]  = mk("reset0",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV);
    tbl[1]  = mk("reset1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV);
    tbl[2]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLEV);
    tbl[3]  = mk("fwd_ex_a",    0, 3, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, fx(2'b01, 2'b00, IDLEV));
    tbl[4]  = mk("fwd_mem_b",   0, 0, 0, 3, 1, 0, 0, 0, 0, 3, 1, 0, fx(2'b00, 2'b10, IDLEV));
    tbl[5]  = mk("fwd_ex_prio", 0, 3, 1, 0, 0, 0, 3, 1, 0, 3, 1, 0, fx(2'b01, 2'b00, IDLEV));
    tbl[6]  = mk("lu_stall",    0, 5, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, STALL);
    tbl[7]  = mk("lu_fwd_ld",   0, 5, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, fx(2'b11, 2'b00, IDLEV));
    tbl[8]  = mk("r0_no_fwd",   0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, IDLEV);
    tbl[9]  = mk("lu_rt",       0, 0, 0, 7, 1, 0, 7, 1, 1, 0, 0, 0, STALL);
    tbl[10] = mk("ex_unused",   0, 4, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, IDLEV);
    tbl[11] = mk("mem_nowr",    0, 6, 1, 0, 0, 0, 0, 0, 0, 6, 0, 0, IDLEV);
    for (int i = 0; i < 12; i++) step(tbl[i]);

    // Single multi-cycle op; a load-use pattern during BUSY must be ignored.
    step(mk("mc_launch", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, IDLEV));
    step(mk("mc_t1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BSTRT));
    step(mk("mc_t2_lu",  0, 2, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, BMID));
    step(mk("mc_t3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BLAST));
    step(mk("mc_t4",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLEV));

    // Back-to-back: second op held in ID during BUSY, launches on first IDLE cycle.
    step(mk("b2b_l1",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, IDLEV));
    step(mk("b2b_t1",    0, 8, 1, 0, 0, 1, 8, 1, 0, 0, 0, 0, fx(2'b01, 2'b00, BSTRT)));
    step(mk("b2b_t2",    0, 8, 1, 0, 0, 1, 8, 1, 0, 0, 0, 0, fx(2'b01, 2'b00, BMID)));
    step(mk("b2b_t3",    0, 8, 1, 0, 0, 1, 8, 1, 0, 0, 0, 0, fx(2'b01, 2'b00, BLAST)));
    step(mk("b2b_l2",    0, 8, 1, 0, 0, 1, 0, 0, 0, 8, 1, 0, fx(2'b10, 2'b00, IDLEV)));
    step(mk("b2b_u1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BSTRT));
    step(mk("b2b_u2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BMID));
    step(mk("b2b_u3",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BLAST));
    step(mk("b2b_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLEV));

    // Load-use together with dmc: bubble only, launch next cycle; then reset mid-BUSY.
    step(mk("ludmc_st",  0, 9, 1, 0, 0, 1, 9, 1, 1, 0, 0, 0, STALL));
    step(mk("ludmc_go",  0, 9, 1, 0, 0, 1, 0, 0, 0, 9, 1, 1, fx(2'b11, 2'b00, IDLEV)));
    step(mk("ludmc_t1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BSTRT));
    step(mk("rst_busy",  1, 3, 1, 3, 1, 1, 3, 1, 0, 0, 0, 0, RSTV));
    step(mk("post_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLEV));
    step(mk("post_rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLEV));

    // Counter starts fresh after the aborted op.
    step(mk("re_launch", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, IDLEV));
    step(mk("re_t1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BSTRT));
    step(mk("re_t2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BMID));
    step(mk("re_t3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BLAST));
    step(mk("re_t4",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLEV));

    // Randomized IDLE-only sweep over a small register range to force collisions.
    for (int i = 0; i < 200; i++) begin
      vec_t v;
      logic lu;
      v = mk("rand", 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0,
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             10'd0);
      lu = v.ewreg && v.em2reg && v.ern != 0 &&
           ((v.urs && v.rs == v.ern) || (v.urt && v.rt == v.ern));
      v.exp = {mfwd(v.rs, v.urs, v.ern, v.ewreg, v.em2reg, v.mrn, v.mwreg, v.mm2reg),
               mfwd(v.rt, v.urt, v.ern, v.ewreg, v.em2reg, v.mrn, v.mwreg, v.mm2reg),
               !lu, 1'b1, lu, 1'b0, 1'b0, 1'b0};
      step(v);
    end

    repeat (2) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
